// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult (5 cycles) and
// div (10 cycles) behind a busy flag, and writes mthi/mtlo immediately.
module e_mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  state_e      state;
  logic [3:0]  cnt;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        wb_en;

  logic        accept;
  logic        is_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  assign accept    = start & ~cancel & (state == IDLE) & (md_op[2:1] != 2'b11);
  assign is_signed = ~md_op[0];
  assign md_stall  = start | busy;

  // Sign-extending to 64 bits makes one unsigned multiplier serve both
  // mult and multu: the low 64 bits of the product are identical.
  always_comb begin
    a_ext = {{32{is_signed & rs_val[31]}}, rs_val};
    b_ext = {{32{is_signed & rt_val[31]}}, rt_val};
    prod  = a_ext * b_ext;
  end

  // Divide on magnitudes and fix signs afterward: truncation toward zero,
  // remainder follows the dividend, and 0x80000000 / -1 falls out as
  // 0x80000000 rem 0 with no special case. A zero divisor is replaced by 1
  // so the datapath never produces X; its result is discarded via wb_en.
  always_comb begin
    a_neg  = is_signed & rs_val[31];
    b_neg  = is_signed & rt_val[31];
    a_mag  = a_neg ? (32'd0 - rs_val) : rs_val;
    b_mag  = b_neg ? (32'd0 - rt_val) : rt_val;
    b_safe = (b_mag == '0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem    = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
      wb_en  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (md_op)
              OP_MULT, OP_MULTU: begin
                res_hi <= prod[63:32];
                res_lo <= prod[31:0];
                cnt    <= 4'd5;
                wb_en  <= 1'b1;
                busy   <= 1'b1;
                state  <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                res_hi <= rem;
                res_lo <= quo;
                cnt    <= 4'd10;
                wb_en  <= |rt_val;
                busy   <= 1'b1;
                state  <= RUN;
              end
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (wb_en) begin
              hi <= res_hi;
              lo <= res_lo;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus queues expected busy-window results
// and mthi/mtlo writes; a negedge monitor pops and compares on each event.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        cancel;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  e_mdu dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .cancel   (cancel),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_busy;
    int unsigned len;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_busy(input int unsigned len, input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.is_busy = 1'b1; e.len = len; e.hi = h; e.lo = l;
    q.push_back(e);
  endtask

  task automatic expect_mt(input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.is_busy = 1'b0; e.len = 0; e.hi = h; e.lo = l;
    q.push_back(e);
  endtask

  // Drive one request for a single clock edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cx);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b; cancel = cx;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("busy_timeout", 32'(busy), 32'd0);
  endtask

  // Monitor: an event is either the end of a busy window or a HI/LO change
  // while idle (mthi/mtlo).
  initial begin : monitor
    logic        prev_busy;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    int unsigned blen;
    exp_t        e;
    prev_busy = 1'b0; prev_hi = '0; prev_lo = '0; blen = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = busy; prev_hi = hi; prev_lo = lo; blen = 0;
      end else begin
        if (busy) blen++;
        if ((prev_busy && !busy) || (!prev_busy && !busy && (hi != prev_hi || lo != prev_lo))) begin
          if (q.size() == 0) begin
            check("unexpected_event", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check("event_kind", 32'(prev_busy), 32'(e.is_busy));
            if (e.is_busy) check("busy_len", blen, e.len);
            check("hi", hi, e.hi);
            check("lo", lo, e.lo);
          end
        end
        if (!busy) blen = 0;
        prev_busy = busy; prev_hi = hi; prev_lo = lo;
      end
    end
  end

  initial begin : stimulus
    int unsigned n;
    start = 1'b0; md_op = '0; rs_val = '0; rt_val = '0; cancel = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_stall", 32'(md_stall), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    expect_busy(5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    issue(3'b000, 32'hFFFFFFFF, 32'd2, 1'b0); wait_idle();
    expect_busy(5, 32'h00000001, 32'hFFFFFFFE);
    issue(3'b001, 32'hFFFFFFFF, 32'd2, 1'b0); wait_idle();
    expect_busy(10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(3'b010, 32'hFFFFFFF9, 32'd2, 1'b0); wait_idle();
    expect_busy(10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(3'b010, 32'hFFFFFFF9, 32'd0, 1'b0); wait_idle();

    expect_mt(32'hFFFFFFFF, 32'h12345678);
    issue(3'b101, 32'h12345678, 32'd0, 1'b0);
    check("mt_no_busy", 32'(busy), 32'd0);
    issue(3'b101, 32'hDEADBEEF, 32'd0, 1'b1);
    expect_mt(32'hCAFEF00D, 32'h12345678);
    issue(3'b100, 32'hCAFEF00D, 32'd0, 1'b0);

    expect_busy(10, 32'h00000000, 32'h80000000);
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0); wait_idle();
    expect_busy(10, 32'h00000001, 32'h7FFFFFFC);
    issue(3'b011, 32'hFFFFFFF9, 32'd2, 1'b0); wait_idle();
    expect_busy(10, 32'h00000001, 32'hFFFFFFFD);
    issue(3'b010, 32'd7, 32'hFFFFFFFE, 1'b0); wait_idle();

    issue(3'b110, 32'h55555555, 32'd3, 1'b0);
    issue(3'b111, 32'h55555555, 32'd3, 1'b0);
    check("reserved_no_busy", 32'(busy), 32'd0);
    expect_mt(32'h11111111, 32'hFFFFFFFD);
    issue(3'b100, 32'h11111111, 32'd0, 1'b0);

    // Cancel during RUN must not abort the multiply.
    expect_busy(5, 32'hFFFFFFFF, 32'hFFFFFFF4);
    issue(3'b000, 32'd3, 32'hFFFFFFFC, 1'b0);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    wait_idle();

    // Reset in busy cycle 3 discards the in-flight multiply.
    issue(3'b000, 32'd5, 32'd5, 1'b0);
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_run_busy", 32'(busy), 32'd0);
    check("rst_run_hi", hi, 32'd0);
    check("rst_run_lo", lo, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    expect_busy(5, 32'd0, 32'd42);
    issue(3'b000, 32'd6, 32'd7, 1'b0); wait_idle();

    // start held two cycles: one 10-cycle window, md_stall covers it all.
    expect_busy(10, 32'd2, 32'd14);
    @(negedge clk);
    start = 1'b1; md_op = 3'b010; rs_val = 32'd100; rt_val = 32'd7;
    #1 check("stall_req1", 32'(md_stall), 32'd1);
    @(negedge clk);
    #1 check("stall_req2", 32'(md_stall), 32'd1);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 30) begin
      #1 check("stall_busy", 32'(md_stall), 32'd1);
      @(negedge clk);
      n++;
    end
    check("held_busy_cycles", n, 32'd9);
    #1 check("stall_after", 32'(md_stall), 32'd0);

    repeat (4) @(negedge clk);
    check("queue_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
